bcd_seg_scan: RTL and testbench

- Downstream consumer of the 4-bit binary-to-BCD stage: accepts a two-digit BCD value (MSD, LSD) and drives a two-digit time-multiplexed seven-segment display.
- Latches digits on a load strobe, alternates digit enables from a refresh counter, and decodes the selected digit to segments.
- Optionally blanks a leading zero; flags illegal (>9) digits with a sticky error.

---
 rtl/bcd_seg_scan.sv | 139 +++++++++++++
 tb/tb_bcd_seg_scan.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_seg_scan.sv
`default_nettype none
// ============================================================================
// Module      : bcd_seg_scan
// Description : Two-digit time-multiplexed seven-segment driver. Holds a
//               BCD pair (MSD, LSD) captured on a load strobe, alternates the
//               digit enables every REFRESH_DIV clocks and decodes the digit
//               being shown. An optional leading-zero blank hides a zero MSD.
//               Illegal digits (>9) raise a sticky error flag.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   REFRESH_DIV : clocks each digit stays enabled per scan slot (>= 2)
//   BLANK_LZ    : 1 = blank segments while a zero MSD is shown
// Ports
//   clk     in   1  system clock, rising edge
//   rst     in   1  asynchronous active-high reset
//   load    in   1  capture msd/lsd on this edge
//   msd     in   4  most significant BCD digit
//   lsd     in   4  least significant BCD digit
//   err_clr in   1  synchronous clear of err
//   seg     out  7  segments {a,b,c,d,e,f,g}, active high, registered
//   an      out  2  one-hot digit enable, an[0]=LSD, an[1]=MSD, registered
//   err     out  1  sticky illegal-digit flag, registered
// ============================================================================
module bcd_seg_scan #(
  parameter int REFRESH_DIV = 4,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] msd,
  input  logic [3:0] lsd,
  input  logic       err_clr,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       err
);

  // Counter width; guarded so a degenerate divider still elaborates.
  localparam int                 c_CNT_W   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(REFRESH_DIV - 1);

  localparam logic [6:0] c_SEG_E   = 7'b1001111;
  localparam logic [1:0] c_AN_LSD  = 2'b01;
  localparam logic [1:0] c_AN_MSD  = 2'b10;

  typedef enum logic [0:0] {
    SCAN_LSD = 1'b0,
    SCAN_MSD = 1'b1
  } scan_e;

  logic [3:0]         r_msd;
  logic [3:0]         r_lsd;
  logic [c_CNT_W-1:0] r_cnt;
  scan_e              r_sel;
  logic [6:0]         r_seg;
  logic [1:0]         r_an;
  logic               r_err;

  logic [3:0]         w_dig;
  logic [6:0]         w_seg_dec;
  logic               w_blank;
  logic [6:0]         w_seg_nxt;
  logic [1:0]         w_an_nxt;
  logic               w_bad_in;
  logic               w_wrap;

  // Digit to segment pattern; every non-BCD code shows "E".
  function automatic logic [6:0] f_dec(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1111110;
      4'd1:    s = 7'b0110000;
      4'd2:    s = 7'b1101101;
      4'd3:    s = 7'b1111001;
      4'd4:    s = 7'b0110011;
      4'd5:    s = 7'b1011011;
      4'd6:    s = 7'b1011111;
      4'd7:    s = 7'b1110000;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1111011;
      default: s = c_SEG_E;
    endcase
    return s;
  endfunction

  // Output selection works on the pre-edge state, so an/seg trail sel by one
  // clock and a digit loaded on a wrap edge is shown in the very next slot.
  always_comb begin
    w_dig     = (r_sel == SCAN_MSD) ? r_msd : r_lsd;
    w_seg_dec = f_dec(w_dig);
    w_blank   = BLANK_LZ && (r_sel == SCAN_MSD) && (r_msd == 4'd0);
    w_seg_nxt = w_blank ? 7'b0000000 : w_seg_dec;
    w_an_nxt  = (r_sel == SCAN_MSD) ? c_AN_MSD : c_AN_LSD;
    w_bad_in  = (msd > 4'd9) || (lsd > 4'd9);
    w_wrap    = (r_cnt == c_CNT_MAX);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_msd <= 4'd0;
      r_lsd <= 4'd0;
      r_cnt <= '0;
      r_sel <= SCAN_LSD;
      r_seg <= 7'b0000000;
      r_an  <= 2'b00;
      r_err <= 1'b0;
    end else begin
      if (load) begin
        r_msd <= msd;
        r_lsd <= lsd;
      end

      if (w_wrap) begin
        r_cnt <= '0;
        r_sel <= (r_sel == SCAN_LSD) ? SCAN_MSD : SCAN_LSD;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end

      r_seg <= w_seg_nxt;
      r_an  <= w_an_nxt;

      // A bad load on the same edge as a clear keeps the flag set.
      if (load && w_bad_in) begin
        r_err <= 1'b1;
      end else if (err_clr) begin
        r_err <= 1'b0;
      end
    end
  end

  assign seg = r_seg;
  assign an  = r_an;
  assign err = r_err;

endmodule
`default_nettype wire

// File: tb/tb_bcd_seg_scan.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd_seg_scan
// Description : Self-checking bench for bcd_seg_scan. Two instances share the
//               stimulus: dut_a (REFRESH_DIV=4, BLANK_LZ=1) and dut_b
//               (REFRESH_DIV=3, BLANK_LZ=0). A reference model derives the
//               expected display from the number of edges since reset and the
//               held digits.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_seg_scan;

  logic       clk = 1'b0;
  logic       rst;
  logic       load;
  logic       err_clr;
  logic [3:0] msd;
  logic [3:0] lsd;

  logic [6:0] seg_a, seg_b;
  logic [1:0] an_a, an_b;
  logic       err_a, err_b;

  int         n_chk = 0;
  int         n_err = 0;

  // Reference state: edges since reset release, held digits, sticky flag.
  int         n_edge;
  logic [3:0] m_msd;
  logic [3:0] m_lsd;
  logic       m_err;

  always #5 clk = ~clk;

  bcd_seg_scan #(.REFRESH_DIV(4), .BLANK_LZ(1'b1)) dut_a (
    .clk(clk), .rst(rst), .load(load), .msd(msd), .lsd(lsd),
    .err_clr(err_clr), .seg(seg_a), .an(an_a), .err(err_a)
  );

  bcd_seg_scan #(.REFRESH_DIV(3), .BLANK_LZ(1'b0)) dut_b (
    .clk(clk), .rst(rst), .load(load), .msd(msd), .lsd(lsd),
    .err_clr(err_clr), .seg(seg_b), .an(an_b), .err(err_b)
  );

  function automatic logic [6:0] ref_dec(input logic [3:0] d);
    logic [6:0] tbl [0:9];
    tbl = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
            7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};
    if (d > 4'd9) return 7'b1001111;
    return tbl[d];
  endfunction

  // Edge n (0-based after release) shows the LSD in even slots, MSD in odd.
  function automatic void ref_out(input int n, input int div, input bit blz,
                                  output logic [1:0] a, output logic [6:0] s);
    if (((n / div) % 2) == 1) begin
      a = 2'b10;
      s = (blz && (m_msd == 4'd0)) ? 7'b0000000 : ref_dec(m_msd);
    end else begin
      a = 2'b01;
      s = ref_dec(m_lsd);
    end
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock edge: model the edge, then compare both instances at edge+1.
  task automatic step();
    logic [1:0] ea_a, ea_b;
    logic [6:0] es_a, es_b;
    @(posedge clk);
    ref_out(n_edge, 4, 1'b1, ea_a, es_a);
    ref_out(n_edge, 3, 1'b0, ea_b, es_b);
    if (load && ((msd > 4'd9) || (lsd > 4'd9))) m_err = 1'b1;
    else if (err_clr)                           m_err = 1'b0;
    if (load) begin
      m_msd = msd;
      m_lsd = lsd;
    end
    n_edge++;
    #1;
    check("an_a",  8'(an_a),  8'(ea_a));
    check("seg_a", 8'(seg_a), 8'(es_a));
    check("err_a", 8'(err_a), 8'(m_err));
    check("an_b",  8'(an_b),  8'(ea_b));
    check("seg_b", 8'(seg_b), 8'(es_b));
    check("err_b", 8'(err_b), 8'(m_err));
  endtask

  task automatic model_reset();
    n_edge = 0;
    m_msd  = 4'd0;
    m_lsd  = 4'd0;
    m_err  = 1'b0;
  endtask

  // Advance until the next edge is position 'pos' of dut_a's 8-edge period.
  task automatic align(input int pos);
    load    = 1'b0;
    err_clr = 1'b0;
    while ((n_edge % 8) != pos) step();
  endtask

  typedef struct {
    logic [3:0] m;
    logic [3:0] l;
    logic [6:0] sl;
    logic [6:0] sm;
    logic       e;
  } vec_t;

  vec_t vt [8];

  initial begin
    // Expected LSD-slot seg, MSD-slot seg (BLANK_LZ=1) and err after load.
    vt[0] = '{4'd1,  4'd5,  7'b1011011, 7'b0110000, 1'b0};
    vt[1] = '{4'd0,  4'd7,  7'b1110000, 7'b0000000, 1'b0};
    vt[2] = '{4'd3,  4'd6,  7'b1011111, 7'b1111001, 1'b0};
    vt[3] = '{4'd2,  4'd4,  7'b0110011, 7'b1101101, 1'b0};
    vt[4] = '{4'd9,  4'd8,  7'b1111111, 7'b1111011, 1'b0};
    vt[5] = '{4'd0,  4'd12, 7'b1001111, 7'b0000000, 1'b1};
    vt[6] = '{4'd15, 4'd0,  7'b1111110, 7'b1001111, 1'b1};
    vt[7] = '{4'd10, 4'd9,  7'b1111011, 7'b1001111, 1'b1};

    rst = 1'b1; load = 1'b0; err_clr = 1'b0; msd = 4'd0; lsd = 4'd0;
    model_reset();

    // Reset held across edges: outputs idle.
    repeat (2) @(posedge clk);
    #1;
    check("rst_an",  8'(an_a),  8'h00);
    check("rst_seg", 8'(seg_a), 8'h00);
    check("rst_err", 8'(err_a), 8'h00);
    check("rst_an_b", 8'(an_b), 8'h00);
    rst = 1'b0;

    // No load: 4 edges of LSD "0", then 4 edges of blanked MSD, twice.
    for (int i = 0; i < 16; i++) begin
      step();
      check("lz_an",  8'(an_a),  ((i % 8) < 4) ? 8'h01 : 8'h02);
      check("lz_seg", 8'(seg_a), ((i % 8) < 4) ? 8'(7'b1111110) : 8'h00);
    end

    // Table vectors: load on the last MSD edge, check the next period.
    for (int k = 0; k < 8; k++) begin
      align(7);
      msd = vt[k].m; lsd = vt[k].l; load = 1'b1; err_clr = 1'b1;
      step();
      load = 1'b0; err_clr = 1'b0;
      step();
      check("tbl_lsd_seg", 8'(seg_a), 8'(vt[k].sl));
      check("tbl_lsd_an",  8'(an_a),  8'h01);
      check("tbl_err",     8'(err_a), 8'(vt[k].e));
      repeat (3) step();
      step();
      check("tbl_msd_seg", 8'(seg_a), 8'(vt[k].sm));
      check("tbl_msd_an",  8'(an_a),  8'h02);
    end

    // Sticky error: set, survives a legal load, cleared, set-wins-over-clear.
    align(0);
    err_clr = 1'b1; step(); err_clr = 1'b0;
    check("err_cleared0", 8'(err_a), 8'h00);
    msd = 4'd0; lsd = 4'd12; load = 1'b1; step(); load = 1'b0;
    check("err_set", 8'(err_a), 8'h01);
    msd = 4'd4; lsd = 4'd5; load = 1'b1; step(); load = 1'b0;
    check("err_sticky", 8'(err_a), 8'h01);
    step();
    check("err_hold", 8'(err_a), 8'h01);
    err_clr = 1'b1; step(); err_clr = 1'b0;
    check("err_clr", 8'(err_a), 8'h00);
    msd = 4'd11; lsd = 4'd2; load = 1'b1; err_clr = 1'b1; step();
    load = 1'b0; err_clr = 1'b0;
    check("err_set_wins", 8'(err_a), 8'h01);

    // Load on the wrap edge: the very next MSD slot shows the new 9.
    align(3);
    msd = 4'd9; lsd = 4'd1; load = 1'b1; step(); load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("wrap_an",  8'(an_a),  8'h02);
      check("wrap_seg", 8'(seg_a), 8'(7'b1111011));
    end

    // Asynchronous reset in the middle of an MSD slot.
    msd = 4'd7; lsd = 4'd12; load = 1'b1; step(); load = 1'b0;
    align(5);
    #3 rst = 1'b1;
    #1;
    check("arst_an",    8'(an_a),  8'h00);
    check("arst_seg",   8'(seg_a), 8'h00);
    check("arst_err",   8'(err_a), 8'h00);
    check("arst_an_b",  8'(an_b),  8'h00);
    check("arst_seg_b", 8'(seg_b), 8'h00);
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    step();
    check("arst_lsd_an",  8'(an_a),  8'h01);
    check("arst_lsd_seg", 8'(seg_a), 8'(7'b1111110));
    repeat (7) step();

    // Randomised traffic checked against the model on both instances.
    for (int i = 0; i < 600; i++) begin
      load    = ($urandom_range(0, 3) == 0);
      err_clr = ($urandom_range(0, 7) == 0);
      msd = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      lsd = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
